// File: rtl/approx_error_monitor.sv
// Exhaustive error sweep for an approximate 2-bit adder: drives all 16 operand
// pairs, samples the adder's 3-bit result and accumulates absolute-error statistics.
module approx_error_monitor #(
  parameter int SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] et,
  input  logic       app_out0,
  input  logic       app_out1,
  input  logic       app_out2,
  output logic       in0,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] max_err,
  output logic [4:0] err_count,
  output logic [6:0] err_sum,
  output logic [3:0] worst_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [1:0] HOLD_LAST = 2'(SETTLE);

  state_t     state_reg, state_next;
  logic [3:0] vec_reg;
  logic [1:0] hold_reg;
  logic       stim_done_reg;

  logic       s1_valid_reg;
  logic [2:0] s1_approx_reg;
  logic [3:0] s1_idx_reg;

  logic [2:0] max_err_reg;
  logic [4:0] err_count_reg;
  logic [6:0] err_sum_reg;
  logic [3:0] worst_vec_reg;

  logic       accept;
  logic       sample_now;
  logic [2:0] exact;
  logic [2:0] err;

  assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
  // The last hold edge of each vector both samples the adder and advances stimulus.
  assign sample_now = (state_reg == RUN) && !stim_done_reg && (hold_reg == HOLD_LAST);

  assign exact = {1'b0, s1_idx_reg[1:0]} + {1'b0, s1_idx_reg[3:2]};
  assign err   = (exact >= s1_approx_reg) ? (exact - s1_approx_reg)
                                          : (s1_approx_reg - exact);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (stim_done_reg) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      vec_reg       <= 4'd0;
      hold_reg      <= 2'd0;
      stim_done_reg <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_approx_reg <= 3'd0;
      s1_idx_reg    <= 4'd0;
      max_err_reg   <= 3'd0;
      err_count_reg <= 5'd0;
      err_sum_reg   <= 7'd0;
      worst_vec_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        vec_reg       <= 4'd0;
        hold_reg      <= 2'd0;
        stim_done_reg <= 1'b0;
        s1_valid_reg  <= 1'b0;
        max_err_reg   <= 3'd0;
        err_count_reg <= 5'd0;
        err_sum_reg   <= 7'd0;
        worst_vec_reg <= 4'd0;
      end else begin
        // Stage 1: valid only on sample edges, so it self-clears outside RUN.
        s1_valid_reg <= sample_now;
        if (sample_now) begin
          s1_approx_reg <= {app_out2, app_out1, app_out0};
          s1_idx_reg    <= vec_reg;
          hold_reg      <= 2'd0;
          if (vec_reg == 4'd15) stim_done_reg <= 1'b1;
          else                  vec_reg       <= vec_reg + 4'd1;
        end else if ((state_reg == RUN) && !stim_done_reg) begin
          hold_reg <= hold_reg + 2'd1;
        end

        // Stage 2: strict > keeps the lowest index among equal worst errors.
        if (s1_valid_reg) begin
          err_sum_reg   <= err_sum_reg + {4'd0, err};
          err_count_reg <= err_count_reg + {4'd0, (err != 3'd0)};
          if (err > max_err_reg) begin
            max_err_reg   <= err;
            worst_vec_reg <= s1_idx_reg;
          end
        end
      end
    end
  end

  assign in0       = vec_reg[0];
  assign in1       = vec_reg[1];
  assign in2       = vec_reg[2];
  assign in3       = vec_reg[3];
  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);
  assign pass      = done && (max_err_reg <= et);
  assign max_err   = max_err_reg;
  assign err_count = err_count_reg;
  assign err_sum   = err_sum_reg;
  assign worst_vec = worst_vec_reg;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Randomized self-checking bench: two monitors (SETTLE=0 and SETTLE=3) sweep a
// table-driven adder model; results are compared to a direct evaluation of all 16 vectors.
module tb_approx_error_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] et;
  logic [2:0] lut [16];

  always #5 clk = ~clk;

  logic       a0_in0, a0_in1, a0_in2, a0_in3, a0_busy, a0_done, a0_pass;
  logic [2:0] a0_max_err;
  logic [4:0] a0_err_count;
  logic [6:0] a0_err_sum;
  logic [3:0] a0_worst_vec;
  logic       a3_in0, a3_in1, a3_in2, a3_in3, a3_busy, a3_done, a3_pass;
  logic [2:0] a3_max_err;
  logic [4:0] a3_err_count;
  logic [6:0] a3_err_sum;
  logic [3:0] a3_worst_vec;

  logic [3:0] vec0, vec3;
  logic [2:0] app0, app3;
  assign vec0 = {a0_in3, a0_in2, a0_in1, a0_in0};
  assign vec3 = {a3_in3, a3_in2, a3_in1, a3_in0};
  assign app0 = lut[vec0];
  assign app3 = lut[vec3];

  approx_error_monitor #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .et(et),
    .app_out0(app0[0]), .app_out1(app0[1]), .app_out2(app0[2]),
    .in0(a0_in0), .in1(a0_in1), .in2(a0_in2), .in3(a0_in3),
    .busy(a0_busy), .done(a0_done), .pass(a0_pass),
    .max_err(a0_max_err), .err_count(a0_err_count),
    .err_sum(a0_err_sum), .worst_vec(a0_worst_vec)
  );

  approx_error_monitor #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .et(et),
    .app_out0(app3[0]), .app_out1(app3[1]), .app_out2(app3[2]),
    .in0(a3_in0), .in1(a3_in1), .in2(a3_in2), .in3(a3_in3),
    .busy(a3_busy), .done(a3_done), .pass(a3_pass),
    .max_err(a3_max_err), .err_count(a3_err_count),
    .err_sum(a3_err_sum), .worst_vec(a3_worst_vec)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Modes: 0 exact adder, 1 output stuck at zero, 2 error only on 1+1, 3 random table.
  task automatic load_lut(input int mode);
    for (int v = 0; v < 16; v++) begin
      int s;
      s = (v & 3) + (v >> 2);
      case (mode)
        0:       lut[v] = 3'(s);
        1:       lut[v] = 3'd0;
        2:       lut[v] = (v == 5) ? 3'd3 : 3'(s);
        default: lut[v] = 3'($urandom_range(0, 7));
      endcase
    end
  endtask

  task automatic run_sweep(input int mode, input logic [2:0] et_v, input bit poke);
    int m_max, m_cnt, m_sum, m_worst, e;
    int lat0, lat3, tb0, tb3, ev0, ev3;
    load_lut(mode);
    m_max = 0; m_cnt = 0; m_sum = 0; m_worst = 0;
    for (int v = 0; v < 16; v++) begin
      e = ((v & 3) + (v >> 2)) - int'(lut[v]);
      if (e < 0) e = -e;
      m_sum += e;
      if (e != 0) m_cnt++;
      if (e > m_max) begin
        m_max = e;
        m_worst = v;
      end
    end
    et = et_v;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("clr0", {a0_done, a0_max_err, a0_err_count, a0_err_sum, a0_worst_vec}, 0);
    check("clr3", {a3_done, a3_max_err, a3_err_count, a3_err_sum, a3_worst_vec}, 0);
    lat0 = -1; lat3 = -1; tb0 = 0; tb3 = 0;
    for (int k = 0; k < 72; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      ev0 = (k >= 15) ? 15 : k;
      ev3 = (k / 4 >= 15) ? 15 : k / 4;
      if (vec0 != 4'(ev0) || a0_busy != (k < 18) || a0_done != (k >= 18)) tb0++;
      if (vec3 != 4'(ev3) || a3_busy != (k < 66) || a3_done != (k >= 66)) tb3++;
      if (a0_done && lat0 < 0) lat0 = k;
      if (a3_done && lat3 < 0) lat3 = k;
      start = poke && (k == 5);
    end
    start = 1'b0;
    $display("sweep mode=%0d et=%0d: model max=%0d cnt=%0d sum=%0d worst=%0d | dut0 lat=%0d max=%0d cnt=%0d sum=%0d worst=%0d pass=%0d",
             mode, et_v, m_max, m_cnt, m_sum, m_worst, lat0, a0_max_err, a0_err_count,
             a0_err_sum, a0_worst_vec, a0_pass);
    check("lat0", lat0, 18);
    check("lat3", lat3, 66);
    check("trace0", tb0, 0);
    check("trace3", tb3, 0);
    check("max0", a0_max_err, m_max);
    check("cnt0", a0_err_count, m_cnt);
    check("sum0", a0_err_sum, m_sum);
    check("worst0", a0_worst_vec, m_worst);
    check("pass0", a0_pass, (m_max <= int'(et_v)));
    check("max3", a3_max_err, m_max);
    check("cnt3", a3_err_count, m_cnt);
    check("sum3", a3_err_sum, m_sum);
    check("worst3", a3_worst_vec, m_worst);
    check("pass3", a3_pass, (m_max <= int'(et_v)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; et = 3'd0;
    load_lut(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out0", {a0_busy, a0_done, a0_pass, a0_max_err, a0_err_count, a0_err_sum, a0_worst_vec, vec0}, 0);
    check("rst_out3", {a3_busy, a3_done, a3_pass, a3_max_err, a3_err_count, a3_err_sum, a3_worst_vec, vec3}, 0);

    run_sweep(0, 3'd0, 1'b0);
    run_sweep(1, 3'd6, 1'b0);
    et = 3'd5; #1;
    check("pass_et5", a0_pass, 0);
    run_sweep(1, 3'd5, 1'b1);
    run_sweep(2, 3'd0, 1'b0);
    for (int r = 0; r < 6; r++) run_sweep(3, 3'($urandom_range(0, 7)), r[0]);

    // Reset while SETTLE=0 monitor is driving vector 7.
    load_lut(0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("vec7", vec0, 7);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    $display("mid-run reset: busy=%0d done=%0d vec=%0d", a0_busy, a0_done, vec0);
    check("midrst0", {a0_busy, a0_done, a0_pass, a0_max_err, a0_err_count, a0_err_sum, a0_worst_vec, vec0}, 0);
    check("midrst3", {a3_busy, a3_done, a3_pass, a3_max_err, a3_err_count, a3_err_sum, a3_worst_vec, vec3}, 0);
    @(posedge clk); #1;
    check("idle_hold", {a0_busy, a0_done, vec0}, 0);
    run_sweep(0, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
